// File: rtl/img_pattern_gen.sv
// img_pattern_gen
//   Image-sensor stand-in for the img_clk domain. On each level change of
//   cmd_frame it emits one frame on a frame-valid / line-valid / 12-bit pixel
//   bus. The pixels form a ramp that starts at PixelInitial each frame and
//   steps by PixelDelta (mod 4096) per pixel, carrying across lines.
//
// Ports
//   clk               in   img_clk, rising-edge logic
//   rst               in   synchronous active-high reset
//   cmd_frame         in   toggle request: every level change asks for a frame
//   img_fv            out  frame valid
//   img_lv            out  line valid
//   img_d             out  pixel data, forced to 0 while img_lv is low
//   status_busy       out  high while img_fv is high
//   status_frameDone  out  toggles once per completed frame
//   status_pixelCount out  pixels emitted in the last/current frame (saturating)
//   dbg_state         out  current FSM state encoding
//
// Handshake: none. cmd_frame is a level-toggle request; a toggle that arrives
// while a frame is in flight is absorbed (the previous level still tracks it),
// so no request is ever queued.
module img_pattern_gen #(
    parameter int          ImgWidth      = 2304,
    parameter int          ImgHeight     = 1296,
    parameter int          FVLeadCycles  = 16,
    parameter int          HBlankCycles  = 8,
    parameter int          FVTrailCycles = 16,
    parameter logic [11:0] PixelInitial  = 12'hFFF,
    parameter int          PixelDelta    = -1,
    localparam int         PcW           = $clog2(ImgWidth * ImgHeight + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_frame,
    output logic           img_fv,
    output logic           img_lv,
    output logic [11:0]    img_d,
    output logic           status_busy,
    output logic           status_frameDone,
    output logic [PcW-1:0] status_pixelCount,
    output logic [2:0]     dbg_state
);

    // One down-counter serves every timed phase, so size it for the longest.
    localparam int Max1   = (ImgWidth > FVLeadCycles) ? ImgWidth : FVLeadCycles;
    localparam int Max2   = (HBlankCycles > FVTrailCycles) ? HBlankCycles : FVTrailCycles;
    localparam int CntMax = (Max1 > Max2) ? Max1 : Max2;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int LineW  = $clog2(ImgHeight + 1);

    localparam logic [11:0]      Delta = 12'(PixelDelta);
    localparam logic [PcW-1:0]   PcMax = PcW'(ImgWidth * ImgHeight);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FV_LEAD  = 3'd1,
        S_LINE     = 3'd2,
        S_HBLANK   = 3'd3,
        S_FV_TRAIL = 3'd4
    } state_t;

    state_t           state;
    logic [CntW-1:0]  cnt;
    logic [LineW-1:0] line_idx;
    logic [11:0]      pixel;
    logic             cmd_prev;
    logic [PcW-1:0]   pc_next;

    // Count saturates at the frame size rather than wrapping.
    always_comb begin
        pc_next = status_pixelCount;
        if (status_pixelCount != PcMax) begin
            pc_next = status_pixelCount + PcW'(1);
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            line_idx          <= '0;
            pixel             <= PixelInitial;
            cmd_prev          <= cmd_frame;   // absorb the current level: no spurious frame
            img_fv            <= 1'b0;
            img_lv            <= 1'b0;
            img_d             <= 12'h000;
            status_busy       <= 1'b0;
            status_frameDone  <= 1'b0;
            status_pixelCount <= '0;
        end else begin
            cmd_prev <= cmd_frame;
            case (state)
                S_IDLE: begin
                    img_lv <= 1'b0;
                    img_d  <= 12'h000;
                    if (cmd_frame != cmd_prev) begin
                        img_fv            <= 1'b1;
                        status_busy       <= 1'b1;
                        status_pixelCount <= '0;
                        pixel             <= PixelInitial;
                        line_idx          <= '0;
                        cnt               <= CntW'(FVLeadCycles - 1);
                        state             <= S_FV_LEAD;
                    end
                end

                // FV_LEAD and HBLANK both end by emitting the first pixel of a line.
                S_FV_LEAD, S_HBLANK: begin
                    if (cnt == '0) begin
                        img_lv            <= 1'b1;
                        img_d             <= pixel;
                        pixel             <= pixel + Delta;
                        status_pixelCount <= pc_next;
                        cnt               <= CntW'(ImgWidth - 1);
                        state             <= S_LINE;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end

                S_LINE: begin
                    if (cnt != '0) begin
                        img_d             <= pixel;
                        pixel             <= pixel + Delta;
                        status_pixelCount <= pc_next;
                        cnt               <= cnt - CntW'(1);
                    end else begin
                        img_lv <= 1'b0;
                        img_d  <= 12'h000;
                        if (line_idx < LineW'(ImgHeight - 1)) begin
                            line_idx <= line_idx + LineW'(1);
                            cnt      <= CntW'(HBlankCycles - 1);
                            state    <= S_HBLANK;
                        end else begin
                            cnt   <= CntW'(FVTrailCycles - 1);
                            state <= S_FV_TRAIL;
                        end
                    end
                end

                S_FV_TRAIL: begin
                    if (cnt == '0) begin
                        img_fv           <= 1'b0;
                        status_busy      <= 1'b0;
                        status_frameDone <= ~status_frameDone;
                        state            <= S_IDLE;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end

                default: begin
                    img_fv      <= 1'b0;
                    img_lv      <= 1'b0;
                    img_d       <= 12'h000;
                    status_busy <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_pattern_gen.sv
// tb_img_pattern_gen
//   Directed bench for img_pattern_gen using a small 4x3 frame (lead 2,
//   hblank 1, trail 2) and a second 4x1 instance starting at 0x002 to
//   exercise the 12-bit wrap.
module tb_img_pattern_gen;

    localparam int W         = 4;
    localparam int H         = 3;
    localparam int LEAD      = 2;
    localparam int HB        = 1;
    localparam int TRAIL     = 2;
    localparam int FRAME_LEN = LEAD + H * W + (H - 1) * HB + TRAIL;  // 18
    localparam int WIN       = FRAME_LEN + 6;

    logic        clk;
    logic        rst;
    logic        cmd_frame;
    logic        fv, lv, busy, frame_done;
    logic [11:0] d;
    logic [3:0]  pix_count;
    logic [2:0]  dbg_state;

    logic        cmd_frame2;
    logic        fv2, lv2, busy2, frame_done2;
    logic [11:0] d2;
    logic [2:0]  pix_count2;
    logic [2:0]  dbg_state2;

    int pass_cnt;
    int check_cnt;

    // Expected per-cycle trace of the 4x3 frame, cycle 0 = fv-rise cycle.
    logic        exp_fv [0:WIN-1];
    logic        exp_lv [0:WIN-1];
    logic [11:0] exp_d  [0:WIN-1];

    img_pattern_gen #(
        .ImgWidth(W), .ImgHeight(H), .FVLeadCycles(LEAD),
        .HBlankCycles(HB), .FVTrailCycles(TRAIL),
        .PixelInitial(12'hFFF), .PixelDelta(-1)
    ) dut (
        .clk(clk), .rst(rst), .cmd_frame(cmd_frame),
        .img_fv(fv), .img_lv(lv), .img_d(d),
        .status_busy(busy), .status_frameDone(frame_done),
        .status_pixelCount(pix_count), .dbg_state(dbg_state)
    );

    img_pattern_gen #(
        .ImgWidth(4), .ImgHeight(1), .FVLeadCycles(2),
        .HBlankCycles(1), .FVTrailCycles(2),
        .PixelInitial(12'h002), .PixelDelta(-1)
    ) dut_wrap (
        .clk(clk), .rst(rst), .cmd_frame(cmd_frame2),
        .img_fv(fv2), .img_lv(lv2), .img_d(d2),
        .status_busy(busy2), .status_frameDone(frame_done2),
        .status_pixelCount(pix_count2), .dbg_state(dbg_state2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic build_model();
        int          c;
        logic [11:0] p;
        for (int i = 0; i < WIN; i++) begin
            exp_fv[i] = 1'b0;
            exp_lv[i] = 1'b0;
            exp_d[i]  = 12'h000;
        end
        c = 0;
        p = 12'hFFF;
        for (int i = 0; i < LEAD; i++) begin exp_fv[c] = 1'b1; c++; end
        for (int l = 0; l < H; l++) begin
            for (int x = 0; x < W; x++) begin
                exp_fv[c] = 1'b1; exp_lv[c] = 1'b1; exp_d[c] = p;
                p = p - 12'h001;
                c++;
            end
            if (l < H - 1) begin
                for (int i = 0; i < HB; i++) begin exp_fv[c] = 1'b1; c++; end
            end
        end
        for (int i = 0; i < TRAIL; i++) begin exp_fv[c] = 1'b1; c++; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int fv_seen;
        rst        = 1'b1;
        cmd_frame  = 1'b1;
        cmd_frame2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fv_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fv !== 1'b0 || fv2 !== 1'b0) fv_seen++;
        end
        check_cnt++;
        if (fv_seen !== 0) $display("FAIL reset_no_frame fv_high_cycles=%0d required 0", fv_seen);
        else pass_cnt++;
        check_cnt++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b required 0", frame_done);
        else pass_cnt++;
        check_cnt++;
        if (pix_count !== 4'd0) $display("FAIL reset_pix_count got %0d required 0", pix_count);
        else pass_cnt++;
        check_cnt++;
        if (lv !== 1'b0 || d !== 12'h000 || busy !== 1'b0)
            $display("FAIL reset_outputs lv=%b d=%h busy=%b required 0", lv, d, busy);
        else pass_cnt++;
        check_cnt++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d required 0", dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int fv_seen;
        @(negedge clk);
        cmd_frame = ~cmd_frame;
        // cycle 8 is the second pixel of line 2 (line 1 = cycles 2..5, hblank 6)
        for (int i = 0; i <= 8; i++) @(negedge clk);
        check_cnt++;
        if (lv !== 1'b1 || d !== 12'hFFA)
            $display("FAIL midrst_pre lv=%b d=%h required lv=1 d=ffa", lv, d);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cnt++;
        if (fv !== 1'b0 || lv !== 1'b0 || d !== 12'h000 || busy !== 1'b0)
            $display("FAIL midrst_outputs fv=%b lv=%b d=%h busy=%b required 0", fv, lv, d, busy);
        else pass_cnt++;
        check_cnt++;
        if (frame_done !== 1'b0) $display("FAIL midrst_frame_done got %b required 0", frame_done);
        else pass_cnt++;
        check_cnt++;
        if (pix_count !== 4'd0) $display("FAIL midrst_pix_count got %0d required 0", pix_count);
        else pass_cnt++;
        fv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fv !== 1'b0) fv_seen++;
        end
        check_cnt++;
        if (fv_seen !== 0) $display("FAIL midrst_no_restart fv_high_cycles=%0d required 0", fv_seen);
        else pass_cnt++;
    endtask

    task automatic test_frame();
        logic fd_before;
        fd_before = frame_done;
        @(negedge clk);
        cmd_frame = ~cmd_frame;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            check_cnt++;
            if (fv !== exp_fv[i]) $display("FAIL frame_fv cyc=%0d got %b required %b", i, fv, exp_fv[i]);
            else pass_cnt++;
            check_cnt++;
            if (busy !== exp_fv[i]) $display("FAIL frame_busy cyc=%0d got %b required %b", i, busy, exp_fv[i]);
            else pass_cnt++;
            check_cnt++;
            if (lv !== exp_lv[i]) $display("FAIL frame_lv cyc=%0d got %b required %b", i, lv, exp_lv[i]);
            else pass_cnt++;
            check_cnt++;
            if (d !== exp_d[i]) $display("FAIL frame_d cyc=%0d got %h required %h", i, d, exp_d[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (frame_done !== ~fd_before)
            $display("FAIL frame_done_toggle got %b required %b", frame_done, ~fd_before);
        else pass_cnt++;
        check_cnt++;
        if (pix_count !== 4'd12) $display("FAIL frame_pix_count got %0d required 12", pix_count);
        else pass_cnt++;
        repeat (20) @(negedge clk);
        check_cnt++;
        if (pix_count !== 4'd12) $display("FAIL frame_pix_hold got %0d required 12", pix_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic fd_before;
        int   fv_len, fd_changes, fv_seen;
        logic fd_last;
        fd_before = frame_done;
        fd_last   = frame_done;
        fd_changes = 0;
        @(negedge clk);
        cmd_frame = ~cmd_frame;
        @(negedge clk);               // fv-rise cycle
        fv_len = (fv === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fv === 1'b1) fv_len++;
        end
        cmd_frame = ~cmd_frame;       // ignored: frame already running
        for (int i = 0; i < 200 && fv === 1'b1; i++) begin
            @(negedge clk);
            if (fv === 1'b1) fv_len++;
            if (frame_done !== fd_last) begin fd_changes++; fd_last = frame_done; end
        end
        check_cnt++;
        if (fv_len !== FRAME_LEN) $display("FAIL b2b_fv_len got %0d required %0d", fv_len, FRAME_LEN);
        else pass_cnt++;
        fv_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (fv !== 1'b0) fv_seen++;
            if (frame_done !== fd_last) begin fd_changes++; fd_last = frame_done; end
        end
        check_cnt++;
        if (fv_seen !== 0) $display("FAIL b2b_no_second fv_high_cycles=%0d required 0", fv_seen);
        else pass_cnt++;
        check_cnt++;
        if (fd_changes !== 1 || frame_done !== ~fd_before)
            $display("FAIL b2b_frame_done changes=%0d required 1", fd_changes);
        else pass_cnt++;
    endtask

    task automatic test_toggle_at_fv_fall();
        int fv_seen;
        @(negedge clk);
        cmd_frame = ~cmd_frame;
        for (int i = 0; i < FRAME_LEN; i++) @(negedge clk);   // now in last fv-high cycle
        check_cnt++;
        if (fv !== 1'b1) $display("FAIL fall_last_fv got %b required 1", fv);
        else pass_cnt++;
        cmd_frame = ~cmd_frame;       // lands on the fv-fall edge: ignored
        fv_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fv !== 1'b0) fv_seen++;
        end
        check_cnt++;
        if (fv_seen !== 0) $display("FAIL fall_toggle_ignored fv_high_cycles=%0d required 0", fv_seen);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic        wl [0:9];
        logic [11:0] wd [0:9];
        for (int i = 0; i < 10; i++) begin wl[i] = 1'b0; wd[i] = 12'h000; end
        wl[2] = 1'b1; wd[2] = 12'h002;
        wl[3] = 1'b1; wd[3] = 12'h001;
        wl[4] = 1'b1; wd[4] = 12'h000;
        wl[5] = 1'b1; wd[5] = 12'hFFF;
        @(negedge clk);
        cmd_frame2 = ~cmd_frame2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_cnt++;
            if (lv2 !== wl[i]) $display("FAIL wrap_lv cyc=%0d got %b required %b", i, lv2, wl[i]);
            else pass_cnt++;
            check_cnt++;
            if (d2 !== wd[i]) $display("FAIL wrap_d cyc=%0d got %h required %h", i, d2, wd[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (pix_count2 !== 3'd4) $display("FAIL wrap_pix_count got %0d required 4", pix_count2);
        else pass_cnt++;
        check_cnt++;
        if (fv2 !== 1'b0 || frame_done2 !== 1'b1)
            $display("FAIL wrap_end fv=%b frame_done=%b required fv=0 frame_done=1", fv2, frame_done2);
        else pass_cnt++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        pass_cnt   = 0;
        check_cnt  = 0;
        rst        = 1'b1;
        cmd_frame  = 1'b1;
        cmd_frame2 = 1'b0;
        build_model();
        test_reset();
        test_mid_reset();
        test_frame();
        test_back_to_back();
        test_toggle_at_fv_fall();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
